// File: rtl/seq_alu_if.sv
// Operand, control and result bundle for the multi-cycle EX-stage ALU.
interface seq_alu_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [3:0]         ctrl_op;
  logic               shift_dir;
  logic               shift_arith;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               carry;
  logic               zero;
  logic               sign;

  modport master (
    output start, ctrl_op, shift_dir, shift_arith,
    output a, b, shamt,
    input  busy, done, result, carry, zero, sign
  );

  modport slave (
    input  start, ctrl_op, shift_dir, shift_arith,
    input  a, b, shamt,
    output busy, done, result, carry, zero, sign
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/add/comp, bit-serial shifts.
// start/busy/done handshake lets the datapath stall on shifts.
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic    clk,
  input logic    rst,
  seq_alu_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0]   res;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   sh_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic               cy;
  logic               sh_out;
  logic               dir;
  logic               arith;
  logic [WIDTH:0]     sum;

  logic launch;
  logic op_xor, op_and, op_add, op_comp;
  logic op_sh, op_br;
  logic sh_zero;
  logic last;

  assign launch  = (state == IDLE) && bus.start;
  assign op_xor  = bus.ctrl_op == 4'b0000;
  assign op_and  = bus.ctrl_op == 4'b0001;
  assign op_add  = bus.ctrl_op == 4'b0010;
  assign op_comp = bus.ctrl_op == 4'b0011;
  assign op_sh   = bus.ctrl_op == 4'b0100;
  assign op_br   = bus.ctrl_op == 4'b0101;
  assign sh_zero = bus.shamt == '0;
  assign last    = cnt == SHAMT_W'(1);
  assign sum     = {1'b0, bus.a} + {1'b0, bus.b};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (launch)
                 nxt = (op_sh && !sh_zero) ? SHIFT : DONE;
      SHIFT:   if (last) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = state == SHIFT;
    bus.done = state == DONE;
  end

  always_comb begin
    if (dir) begin
      sh_out = shreg[0];
      sh_nxt = {arith & shreg[WIDTH-1], shreg[WIDTH-1:1]};
    end else begin
      sh_out = shreg[WIDTH-1];
      sh_nxt = {shreg[WIDTH-2:0], 1'b0};
    end
  end

  // skip and undefined codes fall to default: result and carry hold
  always_ff @(posedge clk) begin
    if (rst) begin
      res   <= '0;
      cy    <= 1'b0;
      shreg <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
      arith <= 1'b0;
    end else if (launch) begin
      unique case (1'b1)
        op_xor:  res <= bus.a ^ bus.b;
        op_and:  res <= bus.a & bus.b;
        op_add:  {cy, res} <= sum;
        op_comp: begin
          res <= -bus.b;
          cy  <= bus.b == '0;
        end
        op_br:   res <= bus.a;
        op_sh: begin
          if (sh_zero) begin
            res <= bus.a;
          end else begin
            shreg <= bus.a;
            cnt   <= bus.shamt;
            cy    <= 1'b0;
            dir   <= bus.shift_dir;
            arith <= bus.shift_arith;
          end
        end
        default: ;
      endcase
    end else if (state == SHIFT) begin
      shreg <= sh_nxt;
      cy    <= sh_out;
      cnt   <= cnt - SHAMT_W'(1);
      if (last) res <= sh_nxt;
    end
  end

  assign bus.result = res;
  assign bus.carry  = cy;
  assign bus.zero   = res == '0;
  assign bus.sign   = res[WIDTH-1];

endmodule
